wb_multiplexer: RTL and testbench
=================================

Name: wb_multiplexer

Overview:
- Single-master to Count-slave Wishbone pipelined-mode interconnect.
- Decodes the top MaskWidth address bits into a slave index and forwards the request to that slave only.
- Latches the selected slave so acknowledge, error and read data are routed back correctly after the master drops address and strobe.
- Sits between a bus master (CPU or test sequencer) and peripherals: slot 0 spare, slot 1 LED register, slot 2 ROM.

Parameters:
- Count, 3, number of slave ports.
- MaskWidth, 4, number of address MSBs used as slave index (addr[AddrWidth-1 -: MaskWidth]).
- DataWidth, 32, data bus width (fixed by package).
- AddrWidth, 32, address bus width (fixed by package).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m_addr, m_data_m, m_sel, m_cyc, m_stb, m_we  in  32/32/4/1/1/1  master request.
- m_data_s, m_ack, m_stall, m_err  out  32/1/1/1  response to master.
- s_addr, s_data_m, s_sel, s_cyc, s_stb, s_we  out  [Count] x 32/32/4/1/1/1  per-slave request, unpacked arrays indexed 0..Count-1.
- s_data_s, s_ack, s_stall, s_err  in  [Count] x 32/1/1/1  per-slave response.

Behaviour:
- Decode: idx = m_addr[31:28]. idx < Count selects slave idx. idx >= Count is unmapped.
- Broadcast: s_addr, s_data_m, s_sel and s_we go to every slave unchanged. s_addr passes the full address, not masked.
- Active slave:
  - While outstanding = 0 and m_stb = 1, the active slave is the decoded idx.
  - Otherwise it is the latched index sel_q.
- Strobe and cycle gating:
  - s_stb[i] = m_stb and (i == decoded idx) and mapped.
  - s_cyc[i] = m_cyc and (i == active slave).
  - All other slaves see cyc = stb = 0.
- Stall: m_stall = s_stall[decoded idx] for a mapped strobe.
  - m_stall = 1 if m_stb targets a slave other than sel_q while outstanding > 0 (no cross-slave pipelining).
  - m_stall = 0 for an unmapped strobe.
- Accept: when m_cyc & m_stb & !m_stall, latch sel_q = idx and increment outstanding. The counter is 4 bits and saturates at 15; the master must not exceed 15 in flight.
- Response:
  - m_ack = s_ack[sel_q] and m_err = s_err[sel_q], combinational from the latched slave, only while m_cyc.
  - m_data_s = s_data_s[sel_q], or 0 when nothing is outstanding.
  - Each ack or err decrements outstanding. Accept and response in the same cycle leave it unchanged.
- Unmapped access: the accept is registered. The cycle after, m_err = 1 for exactly one cycle, m_ack = 0 and m_data_s = 0. No slave sees stb.
- m_cyc deassert: outstanding clears to 0 and sel_q to 0 on the next edge; any late slave acks are dropped.
- Reset (synchronous, overrides everything):
  - outstanding = 0, sel_q = 0, pending unmapped error cleared.
  - Outputs follow combinationally: m_ack = m_err = 0, m_data_s = 0, all s_cyc/s_stb = 0 while m_cyc = 0.
  - Reset mid-transaction abandons it; no ack is forwarded in the following cycle unless a new accept occurs.
- Latency: zero added cycles on the request path (combinational) and the response path (combinational from sel_q).

Decomposition:
- Package wb_pkg: DataWidth = 32, AddrWidth = 32, SelWidth = DataWidth/8, and a slave-index typedef sized by MaskWidth.
- One sub-module, wb_addr_decoder: m_addr -> idx plus mapped flag.
- Counter, latch and routing stay in wb_multiplexer.

Test Plan:
1. Read routing: master strobes read at 0x2000_0000. Slave 2 returns data 0x0000_0005 with ack one cycle later. Required: only s_stb[2] pulses; m_ack = 1 with m_data_s = 0x0000_0005 although m_stb = 0 and m_addr = 0 on the ack cycle.
2. Write routing: write 0x1000_0000, sel = 4'h1, data = 0x5. Required: s_stb[1] = 1, s_we[1] = 1, s_data_m[1] = 0x5; ack from slave 1 reaches m_ack; s_stb[0] and s_stb[2] stay 0.
3. Stall pass-through: slave 2 holds stall for 3 cycles on a 0x2000_0000 strobe. Required: m_stall = 1 for those 3 cycles; outstanding increments only on the first unstalled cycle.
4. Unmapped address: read 0x3000_0000. Required: m_stall = 0; the next cycle m_err = 1 for one cycle and m_ack = 0; no s_stb asserted.
5. Cross-slave stall: strobe slave 2, then strobe slave 1 before slave 2 acks. Required: m_stall = 1 until slave 2 ack is received, then the slave 1 request is accepted.
6. Reset mid-operation: assert reset for 1 cycle between accept and ack of a 0x2000_0000 read. Required: outstanding = 0 afterwards and the subsequent s_ack[2] pulse is not forwarded unless m_cyc plus a new accept.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and types for the Wishbone single-master interconnect.
package wb_pkg;

    localparam int unsigned DataWidth        = 32;
    localparam int unsigned AddrWidth        = 32;
    localparam int unsigned SelWidth         = DataWidth / 8;
    localparam int unsigned DefaultMaskWidth = 4;
    localparam int unsigned CountWidth       = 4;

    typedef logic [DefaultMaskWidth-1:0] slave_idx_t;

endpackage

// File: rtl/wb_addr_decoder.sv
// Turns the slave-index bits of the master address into an index and a mapped flag.
module wb_addr_decoder #(
    parameter int unsigned Count     = 3,
    parameter int unsigned MaskWidth = 4
) (
    input  logic [MaskWidth-1:0] addr_msb_i,
    output logic [MaskWidth-1:0] idx_o,
    output logic                 mapped_o
);

    always_comb begin
        idx_o    = addr_msb_i;
        mapped_o = (int'(addr_msb_i) < int'(Count));
    end

endmodule

// File: rtl/wb_multiplexer.sv
// Single-master to Count-slave Wishbone pipelined interconnect with latched response routing.
module wb_multiplexer
    import wb_pkg::*;
#(
    parameter int unsigned Count     = 3,
    parameter int unsigned MaskWidth = DefaultMaskWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AddrWidth-1:0]  m_addr,
    input  logic [DataWidth-1:0]  m_data_m,
    input  logic [SelWidth-1:0]   m_sel,
    input  logic                  m_cyc,
    input  logic                  m_stb,
    input  logic                  m_we,
    output logic [DataWidth-1:0]  m_data_s,
    output logic                  m_ack,
    output logic                  m_stall,
    output logic                  m_err,
    output logic [AddrWidth-1:0]  s_addr   [Count],
    output logic [DataWidth-1:0]  s_data_m [Count],
    output logic [SelWidth-1:0]   s_sel    [Count],
    output logic                  s_cyc    [Count],
    output logic                  s_stb    [Count],
    output logic                  s_we     [Count],
    input  logic [DataWidth-1:0]  s_data_s [Count],
    input  logic                  s_ack    [Count],
    input  logic                  s_stall  [Count],
    input  logic                  s_err    [Count]
);

    logic [MaskWidth-1:0]  dec_idx;
    logic                  mapped;
    logic [MaskWidth-1:0]  act_idx;

    logic [CountWidth-1:0] count_q, count_d;
    logic [MaskWidth-1:0]  sel_q, sel_d;
    logic                  err_q, err_d;

    logic                  busy;
    logic                  sel_ack, sel_err;
    logic [DataWidth-1:0]  sel_data;
    logic                  dec_stall;
    logic                  accept, inc, resp;

    wb_addr_decoder #(
        .Count     (Count),
        .MaskWidth (MaskWidth)
    ) u_dec (
        .addr_msb_i (m_addr[AddrWidth-1 -: MaskWidth]),
        .idx_o      (dec_idx),
        .mapped_o   (mapped)
    );

    assign busy = (count_q != '0);

    // Loop-based muxes keep unmapped index values from reading outside the slave arrays.
    always_comb begin
        sel_ack   = 1'b0;
        sel_err   = 1'b0;
        sel_data  = '0;
        dec_stall = 1'b0;
        for (int unsigned i = 0; i < Count; i++) begin
            if (sel_q == MaskWidth'(i)) begin
                sel_ack  = s_ack[i];
                sel_err  = s_err[i];
                sel_data = s_data_s[i];
            end
            if (dec_idx == MaskWidth'(i)) begin
                dec_stall = s_stall[i];
            end
        end
    end

    always_comb begin
        act_idx = (!busy && m_stb) ? dec_idx : sel_q;
        for (int unsigned i = 0; i < Count; i++) begin
            s_addr[i]   = m_addr;
            s_data_m[i] = m_data_m;
            s_sel[i]    = m_sel;
            s_we[i]     = m_we;
            s_stb[i]    = m_stb && mapped && (dec_idx == MaskWidth'(i));
            s_cyc[i]    = m_cyc && (act_idx == MaskWidth'(i));
        end
    end

    always_comb begin
        m_stall  = m_stb && mapped && ((busy && (dec_idx != sel_q)) || dec_stall);
        m_ack    = m_cyc && busy && sel_ack;
        m_err    = m_cyc && ((busy && sel_err) || err_q);
        m_data_s = busy ? sel_data : '0;
    end

    always_comb begin
        accept  = m_cyc && m_stb && !m_stall;
        inc     = accept && mapped && (count_q != '1);
        resp    = m_cyc && busy && (sel_ack || sel_err);
        count_d = count_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        if (!m_cyc) begin
            count_d = '0;
            sel_d   = '0;
        end else begin
            if (inc && !resp) begin
                count_d = count_q + 1'b1;
            end else if (!inc && resp) begin
                count_d = count_q - 1'b1;
            end
            if (accept && mapped) begin
                sel_d = dec_idx;
            end
            // Unmapped accepts never count as outstanding; they only arm a one-cycle error.
            err_d = accept && !mapped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_multiplexer.sv
// Directed bench for wb_multiplexer; the bench itself plays all three slaves.
module tb_wb_multiplexer;
    import wb_pkg::*;

    localparam int unsigned N = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [AddrWidth-1:0] m_addr;
    logic [DataWidth-1:0] m_data_m;
    logic [SelWidth-1:0]  m_sel;
    logic                 m_cyc, m_stb, m_we;
    logic [DataWidth-1:0] m_data_s;
    logic                 m_ack, m_stall, m_err;
    logic [AddrWidth-1:0] s_addr   [N];
    logic [DataWidth-1:0] s_data_m [N];
    logic [SelWidth-1:0]  s_sel    [N];
    logic                 s_cyc    [N];
    logic                 s_stb    [N];
    logic                 s_we     [N];
    logic [DataWidth-1:0] s_data_s [N];
    logic                 s_ack    [N];
    logic                 s_stall  [N];
    logic                 s_err    [N];

    logic [2:0] stb_v, cyc_v;
    slave_idx_t probe_idx;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    always_comb begin
        stb_v = {s_stb[2], s_stb[1], s_stb[0]};
        cyc_v = {s_cyc[2], s_cyc[1], s_cyc[0]};
    end

    wb_multiplexer #(
        .Count     (N),
        .MaskWidth (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m_addr   (m_addr),
        .m_data_m (m_data_m),
        .m_sel    (m_sel),
        .m_cyc    (m_cyc),
        .m_stb    (m_stb),
        .m_we     (m_we),
        .m_data_s (m_data_s),
        .m_ack    (m_ack),
        .m_stall  (m_stall),
        .m_err    (m_err),
        .s_addr   (s_addr),
        .s_data_m (s_data_m),
        .s_sel    (s_sel),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_data_s (s_data_s),
        .s_ack    (s_ack),
        .s_stall  (s_stall),
        .s_err    (s_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        m_addr   = '0;
        m_data_m = '0;
        m_sel    = '0;
        m_cyc    = 1'b0;
        m_stb    = 1'b0;
        m_we     = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            s_data_s[i] = '0;
            s_ack[i]    = 1'b0;
            s_stall[i]  = 1'b0;
            s_err[i]    = 1'b0;
        end
        probe_idx = 4'h2;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_ack",  32'(m_ack), 32'd0);
        chk("rst_err",  32'(m_err), 32'd0);
        chk("rst_data", m_data_s,   32'd0);
        chk("rst_cyc",  32'(cyc_v), 32'd0);
        chk("rst_stb",  32'(stb_v), 32'd0);

        // 1: read routing to slave 2
        s_data_s[2] = 32'h0000_0005;
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_addr = {probe_idx, 28'h0};
        #1;
        chk("rd_stb",   32'(stb_v),   32'b100);
        chk("rd_cyc",   32'(cyc_v),   32'b100);
        chk("rd_stall", 32'(m_stall), 32'd0);
        chk("rd_data0", m_data_s,     32'd0);
        tick();
        m_stb    = 1'b0;
        m_addr   = '0;
        s_ack[2] = 1'b1;
        #1;
        chk("rd_ack",     32'(m_ack), 32'd1);
        chk("rd_data",    m_data_s,   32'h0000_0005);
        chk("rd_stb_off", 32'(stb_v), 32'd0);
        chk("rd_cyc_hold",32'(cyc_v), 32'b100);
        tick();
        s_ack[2] = 1'b0;
        m_cyc    = 1'b0;
        #1;
        chk("rd_ack_off", 32'(m_ack), 32'd0);
        tick();

        // 2: write routing to slave 1
        m_cyc    = 1'b1;
        m_stb    = 1'b1;
        m_we     = 1'b1;
        m_addr   = 32'h1000_0000;
        m_sel    = 4'h1;
        m_data_m = 32'h5;
        #1;
        chk("wr_stb",  32'(stb_v),       32'b010);
        chk("wr_we",   32'(s_we[1]),     32'd1);
        chk("wr_data", s_data_m[1],      32'h5);
        chk("wr_sel",  32'(s_sel[1]),    32'h1);
        chk("wr_addr", s_addr[1],        32'h1000_0000);
        tick();
        m_stb    = 1'b0;
        s_ack[1] = 1'b1;
        #1;
        chk("wr_ack",     32'(m_ack), 32'd1);
        chk("wr_stb_off", 32'(stb_v), 32'd0);
        tick();
        s_ack[1] = 1'b0;
        m_cyc    = 1'b0;
        m_we     = 1'b0;
        tick();

        // 3: stall pass-through from slave 2; data visible only once outstanding
        s_stall[2]  = 1'b1;
        s_data_s[2] = 32'h0000_00AA;
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_addr = 32'h2000_0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_stall", 32'(m_stall), 32'd1);
            chk("st_nocnt", m_data_s,     32'd0);
            tick();
        end
        s_stall[2] = 1'b0;
        #1;
        chk("st_free", 32'(m_stall), 32'd0);
        tick();
        m_stb    = 1'b0;
        s_ack[2] = 1'b1;
        #1;
        chk("st_cnt1", m_data_s,   32'h0000_00AA);
        chk("st_ack",  32'(m_ack), 32'd1);
        tick();
        s_ack[2] = 1'b0;
        #1;
        chk("st_cnt0", m_data_s, 32'd0);
        m_cyc = 1'b0;
        tick();

        // 4: unmapped address
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_addr = 32'h3000_0000;
        #1;
        chk("um_stall", 32'(m_stall), 32'd0);
        chk("um_stb",   32'(stb_v),   32'd0);
        chk("um_err0",  32'(m_err),   32'd0);
        tick();
        m_stb = 1'b0;
        #1;
        chk("um_err",  32'(m_err), 32'd1);
        chk("um_ack",  32'(m_ack), 32'd0);
        chk("um_data", m_data_s,   32'd0);
        tick();
        chk("um_err1", 32'(m_err), 32'd0);
        m_cyc = 1'b0;
        tick();

        // 5: cross-slave stall
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_addr = 32'h2000_0000;
        #1;
        chk("xs_first", 32'(m_stall), 32'd0);
        tick();
        m_addr = 32'h1000_0000;
        #1;
        chk("xs_stall1", 32'(m_stall), 32'd1);
        chk("xs_cyc1",   32'(cyc_v),   32'b100);
        tick();
        s_ack[2] = 1'b1;
        #1;
        chk("xs_stall2", 32'(m_stall), 32'd1);
        chk("xs_ack2",   32'(m_ack),   32'd1);
        tick();
        s_ack[2] = 1'b0;
        #1;
        chk("xs_go",   32'(m_stall), 32'd0);
        chk("xs_cyc2", 32'(cyc_v),   32'b010);
        tick();
        m_stb       = 1'b0;
        s_data_s[1] = 32'h0000_0077;
        s_ack[1]    = 1'b1;
        #1;
        chk("xs_ack1",  32'(m_ack), 32'd1);
        chk("xs_data1", m_data_s,   32'h0000_0077);
        tick();
        s_ack[1] = 1'b0;
        m_cyc    = 1'b0;
        tick();

        // 6: reset between accept and ack abandons the read
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_addr = 32'h2000_0000;
        tick();
        m_stb = 1'b0;
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        s_ack[2] = 1'b1;
        #1;
        chk("rs_ack",  32'(m_ack), 32'd0);
        chk("rs_data", m_data_s,   32'd0);
        chk("rs_cyc",  32'(cyc_v), 32'b001);
        tick();
        s_ack[2] = 1'b0;
        m_stb    = 1'b1;
        tick();
        m_stb    = 1'b0;
        s_ack[2] = 1'b1;
        #1;
        chk("rs_new_ack", 32'(m_ack), 32'd1);
        tick();
        s_ack[2] = 1'b0;

        // m_cyc drop discards a late ack
        m_stb = 1'b1;
        tick();
        m_stb = 1'b0;
        m_cyc = 1'b0;
        tick();
        s_ack[2] = 1'b1;
        m_cyc    = 1'b1;
        #1;
        chk("cd_ack", 32'(m_ack), 32'd0);
        tick();
        s_ack[2] = 1'b0;
        m_cyc    = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
